// File: rtl/pfd_pkg.sv
// rtl/pfd_pkg.sv - shared state type and sizing helpers for the sampled PFD/TDC
package pfd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UP_PEND = 2'd1,
    DN_PEND = 2'd2
  } pfd_state_e;

  // Largest magnitude a signed err word may carry; the most-negative code is never used.
  function automatic int err_max(input int err_w);
    return (1 << (err_w - 1)) - 1;
  endfunction

  function automatic int lock_cnt_w(input int lock_cnt);
    return $clog2(lock_cnt + 1);
  endfunction

endpackage

// File: rtl/pfd_edge_sync.sv
// rtl/pfd_edge_sync.sv - multi-flop synchroniser followed by a registered rising-edge pulse
module pfd_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              edge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
      edge_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/pfd_tdc.sv
// rtl/pfd_tdc.sv - tri-state PFD with signed CLK-quantised phase error, saturation and valid strobe
// Optional lock detector built only when PFD_LOCK_DET_EN is defined; otherwise locked is tied low.
module pfd_tdc
  import pfd_pkg::*;
#(
  parameter int ERR_W       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    IN,
  input  logic                    FB,
  output logic                    flagu,
  output logic                    flagd,
  output logic signed [ERR_W-1:0] err,
  output logic                    err_valid,
  output logic                    err_sat,
  output logic                    locked
);

  localparam logic [ERR_W-1:0] CNT_MAX = ERR_W'(err_max(ERR_W));

  logic in_edge, fb_edge;

  pfd_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_in (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .async_i (IN),
    .edge_o  (in_edge)
  );

  pfd_edge_sync #(.STAGES(SYNC_STAGES)) u_sync_fb (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .async_i (FB),
    .edge_o  (fb_edge)
  );

  pfd_state_e              state_q, state_d;
  logic [ERR_W-1:0]        count_q, count_d, count_inc;
  logic signed [ERR_W-1:0] err_q, err_d;
  logic                    err_valid_q, err_valid_d;
  logic                    err_sat_q, err_sat_d;
  logic                    flagu_q, flagd_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      count_q     <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      err_sat_q   <= 1'b0;
      flagu_q     <= 1'b0;
      flagd_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      err_sat_q   <= err_sat_d;
      flagu_q     <= (state_d == UP_PEND);
      flagd_q     <= (state_d == DN_PEND);
    end
  end

  // count sticks at CNT_MAX so an unanswered edge never wraps into a bogus small error
  assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + ERR_W'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    err_d       = err_q;
    err_valid_d = 1'b0;
    err_sat_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_edge && fb_edge) begin
          err_d       = '0;
          err_valid_d = 1'b1;
        end else if (in_edge) begin
          state_d = UP_PEND;
          count_d = ERR_W'(1);
        end else if (fb_edge) begin
          state_d = DN_PEND;
          count_d = ERR_W'(1);
        end
      end
      UP_PEND: begin
        if (fb_edge) begin
          state_d     = IDLE;
          err_d       = $signed(count_q);
          err_valid_d = 1'b1;
          err_sat_d   = (count_q == CNT_MAX);
          count_d     = '0;
        end else begin
          count_d = count_inc;
        end
      end
      DN_PEND: begin
        if (in_edge) begin
          state_d     = IDLE;
          err_d       = -$signed(count_q);
          err_valid_d = 1'b1;
          err_sat_d   = (count_q == CNT_MAX);
          count_d     = '0;
        end else begin
          count_d = count_inc;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign flagu     = flagu_q;
  assign flagd     = flagd_q;
  assign err       = err_q;
  assign err_valid = err_valid_q;
  assign err_sat   = err_sat_q;

`ifdef PFD_LOCK_DET_EN
  localparam int                      LCW      = lock_cnt_w(LOCK_CNT);
  localparam logic [LCW-1:0]          LOCK_TGT = LCW'(LOCK_CNT);
  localparam logic signed [ERR_W-1:0] TOL      = ERR_W'(LOCK_TOL);

  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           locked_q;
  logic           in_tol;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    in_tol     = (err_q <= TOL) && (err_q >= -TOL) && !err_sat_q;
    if (err_valid_q) begin
      if (!in_tol)
        lock_cnt_d = '0;
      else if (lock_cnt_q != LOCK_TGT)
        lock_cnt_d = lock_cnt_q + LCW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= (lock_cnt_d == LOCK_TGT);
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_tdc.sv
// tb/tb_pfd_tdc.sv - directed self-checking bench for pfd_tdc (ERR_W=12 and ERR_W=4 instances)
module tb_pfd_tdc;

  logic clk = 1'b0;
  logic rst, in_clk, fb_clk;

  logic               flagu, flagd, ev, es, locked;
  logic signed [11:0] err;
  logic               flagu4, flagd4, ev4, es4, locked4;
  logic signed [3:0]  err4;

  always #5 clk = ~clk;

  pfd_tdc #(.ERR_W(12), .SYNC_STAGES(2), .LOCK_TOL(2), .LOCK_CNT(4)) dut (
    .CLK(clk), .RESET(rst), .IN(in_clk), .FB(fb_clk),
    .flagu(flagu), .flagd(flagd), .err(err), .err_valid(ev), .err_sat(es), .locked(locked)
  );

  pfd_tdc #(.ERR_W(4), .SYNC_STAGES(2), .LOCK_TOL(2), .LOCK_CNT(4)) dut4 (
    .CLK(clk), .RESET(rst), .IN(in_clk), .FB(fb_clk),
    .flagu(flagu4), .flagd(flagd4), .err(err4), .err_valid(ev4), .err_sat(es4), .locked(locked4)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int nu, nd, nboth, nv, e, s, nv4, e4, s4, lk_after, lk_end;

  // IN rises in loop cycle a, FB in cycle b; each held high two cycles, then a quiet tail
  task automatic run(input int a, input int b);
    bit pend;
    nu = 0; nd = 0; nboth = 0; nv = 0; e = 999; s = -1;
    nv4 = 0; e4 = 999; s4 = -1; lk_after = -1; pend = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      in_clk = (c >= a) && (c < a + 2);
      fb_clk = (c >= b) && (c < b + 2);
      @(negedge clk);
      if (pend) begin lk_after = int'(locked); pend = 0; end
      nu    += int'(flagu);
      nd    += int'(flagd);
      nboth += int'(flagu & flagd);
      if (ev)  begin nv++;  e  = int'(err);  s  = int'(es);  pend = 1; end
      if (ev4) begin nv4++; e4 = int'(err4); s4 = int'(es4); end
    end
    lk_end = int'(locked);
  endtask

  initial begin
    int found, rv, rf;
    rst = 1'b1; in_clk = 1'b0; fb_clk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flagu", int'(flagu), 0);
    check("rst_flagd", int'(flagd), 0);
    check("rst_err", int'(err), 0);
    check("rst_valid", int'(ev), 0);
    check("rst_sat", int'(es), 0);
    check("rst_locked", int'(locked), 0);
    @(posedge clk); #2 rst = 1'b0;

    run(1, 6);
    check("lead5_nu", nu, 5);   check("lead5_nd", nd, 0);
    check("lead5_nv", nv, 1);   check("lead5_err", e, 5);
    check("lead5_sat", s, 0);   check("lead5_err4", e4, 5);
    check("lead5_both", nboth, 0);

    run(4, 1);
    check("lag3_nd", nd, 3);    check("lag3_nu", nu, 0);
    check("lag3_nv", nv, 1);    check("lag3_err", e, -3);

    run(2, 2);
    check("same_nv", nv, 1);    check("same_err", e, 0);
    check("same_nu", nu, 0);    check("same_nd", nd, 0);
    check("same_sat", s, 0);

    run(1, 13);
    check("sat_err4", e4, 7);   check("sat_sat4", s4, 1);
    check("sat_nv4", nv4, 1);   check("sat_err12", e, 12);
    check("sat_sat12", s, 0);   check("sat_nu", nu, 12);

    run(11, 1);
    check("nsat_err4", e4, -7); check("nsat_sat4", s4, 1);
    check("nsat_err12", e, -10);

    // reset two cycles into UP_PEND
    found = 0; rv = 0; rf = 0;
    @(posedge clk); #2 in_clk = 1'b1;
    @(posedge clk); #2 in_clk = 1'b0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (flagu) found = 1;
    end
    check("rst_mid_enter", found, 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rv += int'(ev);
      rf += int'(flagu | flagd);
    end
    check("rst_mid_nv", rv, 0);
    check("rst_mid_flags", rf, 0);
    check("rst_mid_err", int'(err), 0);

    run(1, 4);
    check("post_rst_err", e, 3);
    check("post_rst_nu", nu, 3);

`ifdef PFD_LOCK_DET_EN
    run(1, 2);  check("lk1_err", e, 1);
    run(3, 1);  check("lk2_err", e, -2);
    run(1, 1);  check("lk3_locked", lk_end, 0);
    run(1, 2);  check("lk4_after", lk_after, 1);
    check("lk4_end", lk_end, 1);
    run(1, 6);  check("lk5_after", lk_after, 0);
`else
    run(1, 2);
    check("nolock_err", e, 1);
    check("nolock_locked", lk_end, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
